// File: rtl/crossbar_out_port.sv
// Crossbar output port: locks onto one granted source per packet
// and buffers its beats in a 2-entry FIFO toward the sink.
module crossbar_out_port #(
    parameter int S_DATA_COUNT = 2,
    parameter int M_DATA_COUNT = 3,
    parameter int T_DATA_WIDTH = 8,
    parameter int PORT_NUMBER  = 0,
    localparam int T_ID___WIDTH = $clog2(S_DATA_COUNT),
    localparam int T_DEST_WIDTH = $clog2(M_DATA_COUNT)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic [S_DATA_COUNT-1:0][T_DATA_WIDTH-1:0] s_data_i,
    input  logic [S_DATA_COUNT-1:0][T_DEST_WIDTH-1:0] s_dest_i,
    input  logic [S_DATA_COUNT-1:0] s_last_i,
    input  logic [S_DATA_COUNT-1:0] s_valid_i,
    output logic [S_DATA_COUNT-1:0] s_ready_o,
    input  logic [S_DATA_COUNT-1:0] grant_i,
    output logic arb_ready_o,
    output logic arb_last_o,
    output logic [T_DATA_WIDTH-1:0] m_data_o,
    output logic [T_ID___WIDTH-1:0] m_id_o,
    output logic [T_DEST_WIDTH-1:0] m_dest_o,
    output logic m_last_o,
    output logic m_valid_o,
    input  logic m_ready_i,
    output logic err_o,
    output logic [15:0] pkt_cnt_o
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    typedef struct packed {
        logic [T_DATA_WIDTH-1:0] data;
        logic [T_ID___WIDTH-1:0] id;
        logic [T_DEST_WIDTH-1:0] dest;
        logic                    last;
    } beat_t;

    state_t state_q;
    state_t state_d;
    logic [T_ID___WIDTH-1:0] sel_q;
    logic [T_ID___WIDTH-1:0] sel_d;

    beat_t      fifo_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic [1:0] count_d;
    beat_t      head;
    beat_t      in_beat;

    logic        err_q;
    logic        err_d;
    logic [15:0] pkt_cnt_q;

    logic                    grant_any;
    logic                    grant_multi;
    logic [T_ID___WIDTH-1:0] grant_idx;

    logic locked;
    logic full;
    logic push;
    logic pop;
    logic dest_bad;

    assign locked = (state_q == LOCKED);
    assign full   = (count_q == 2'd2);

    // Ready depends only on registered lock, select and occupancy.
    always_comb begin
        s_ready_o = '0;
        for (int i = 0; i < S_DATA_COUNT; i++) begin
            s_ready_o[i] = locked && !full &&
                (sel_q == T_ID___WIDTH'(i));
        end
    end

    assign push = locked && !full && s_valid_i[sel_q];
    assign pop  = (count_q != 2'd0) && m_ready_i;

    assign dest_bad = s_dest_i[sel_q] !=
        T_DEST_WIDTH'(PORT_NUMBER);

    assign in_beat.data = s_data_i[sel_q];
    assign in_beat.id   = sel_q;
    assign in_beat.dest = s_dest_i[sel_q];
    assign in_beat.last = s_last_i[sel_q];

    assign arb_last_o  = push && s_last_i[sel_q];
    assign arb_ready_o = !full;

    // Decode the grant vector: flag zero, one or several set bits.
    always_comb begin
        grant_any   = 1'b0;
        grant_multi = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < S_DATA_COUNT; i++) begin
            if (grant_i[i]) begin
                if (grant_any) begin
                    grant_multi = 1'b1;
                end
                grant_any = 1'b1;
                grant_idx = T_ID___WIDTH'(i);
            end
        end
    end

    // Lock FSM: take a single-bit grant, release after the last beat.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        unique case (state_q)
            IDLE: begin
                if (grant_any && !grant_multi) begin
                    state_d = LOCKED;
                    sel_d   = grant_idx;
                end
            end
            LOCKED: begin
                if (push && s_last_i[sel_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sticky error: ambiguous grant or a beat aimed at another port.
    always_comb begin
        err_d = err_q;
        if (!locked && grant_multi) begin
            err_d = 1'b1;
        end
        if (push && dest_bad) begin
            err_d = 1'b1;
        end
    end

    // Occupancy tracks push/pop; both at once leaves it unchanged.
    always_comb begin
        count_d = count_q;
        unique case (1'b1)
            (push && !pop): count_d = count_q + 2'd1;
            (pop && !push): count_d = count_q - 2'd1;
            default:        count_d = count_q;
        endcase
    end

    // FSM, select and error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
        end
    end

    // FIFO pointers and occupancy; reset drops any buffered beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    // FIFO storage written at the write pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
        end else if (push) begin
            fifo_q[wr_ptr_q] <= in_beat;
        end
    end

    // Count packets as their last beat leaves the port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt_q <= 16'd0;
        end else if (pop && head.last) begin
            pkt_cnt_q <= pkt_cnt_q + 16'd1;
        end
    end

    assign head = fifo_q[rd_ptr_q];

    assign m_valid_o = (count_q != 2'd0);
    assign m_data_o  = head.data;
    assign m_id_o    = head.id;
    assign m_dest_o  = head.dest;
    assign m_last_o  = head.last;
    assign err_o     = err_q;
    assign pkt_cnt_o = pkt_cnt_q;

endmodule

// File: tb/tb_crossbar_out_port.sv
// Bench for crossbar_out_port: scoreboard of driven beats checked
// against every output beat, plus per-scenario inline checks.
module tb_crossbar_out_port;

    logic            clk;
    logic            rst_n;
    logic [1:0][7:0] s_data_i;
    logic [1:0][1:0] s_dest_i;
    logic [1:0]      s_last_i;
    logic [1:0]      s_valid_i;
    logic [1:0]      s_ready_o;
    logic [1:0]      grant_i;
    logic            arb_ready_o;
    logic            arb_last_o;
    logic [7:0]      m_data_o;
    logic [0:0]      m_id_o;
    logic [1:0]      m_dest_o;
    logic            m_last_o;
    logic            m_valid_o;
    logic            m_ready_i;
    logic            err_o;
    logic [15:0]     pkt_cnt_o;

    typedef struct {
        logic [7:0] d;
        logic [0:0] id;
        logic [1:0] dest;
        logic       last;
    } exp_t;

    exp_t exp_q[$];
    int   acc_cyc_q[$];
    int   pop_cyc_q[$];
    int   tests_run;
    int   failed;
    int   cyc;
    int   pops;
    int   arb_cnt;

    crossbar_out_port #(
        .S_DATA_COUNT(2),
        .M_DATA_COUNT(3),
        .T_DATA_WIDTH(8),
        .PORT_NUMBER(0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .s_data_i(s_data_i),
        .s_dest_i(s_dest_i),
        .s_last_i(s_last_i),
        .s_valid_i(s_valid_i),
        .s_ready_o(s_ready_o),
        .grant_i(grant_i),
        .arb_ready_o(arb_ready_o),
        .arb_last_o(arb_last_o),
        .m_data_o(m_data_o),
        .m_id_o(m_id_o),
        .m_dest_o(m_dest_o),
        .m_last_o(m_last_o),
        .m_valid_o(m_valid_o),
        .m_ready_i(m_ready_i),
        .err_o(err_o),
        .pkt_cnt_o(pkt_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: head must match the oldest expected beat.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (arb_last_o) arb_cnt++;
            if (m_valid_o) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    failed++;
                    $display("FAIL sb_extra: got data=%h id=%0d, required no beat",
                             m_data_o, m_id_o);
                end else begin
                    e = exp_q[0];
                    if (m_data_o !== e.d || m_id_o !== e.id ||
                        m_dest_o !== e.dest || m_last_o !== e.last) begin
                        failed++;
                        $display("FAIL sb_head: got %h/%0d/%0d/%0b, required %h/%0d/%0d/%0b",
                                 m_data_o, m_id_o, m_dest_o, m_last_o,
                                 e.d, e.id, e.dest, e.last);
                    end
                    if (m_ready_i) begin
                        void'(exp_q.pop_front());
                        pops++;
                        pop_cyc_q.push_back(cyc);
                    end
                end
            end
        end
    end

    task automatic give_grant(input logic [1:0] g);
        grant_i = g;
        @(posedge clk); #1;
        grant_i = 2'b00;
    endtask

    task automatic send_pkt(input int src, input int n,
                            input logic [7:0] base,
                            input logic [1:0] dest,
                            input bit with_last);
        exp_t e;
        int   w;
        for (int i = 0; i < n; i++) begin
            s_data_i[src]  = base + 8'(i);
            s_dest_i[src]  = dest;
            s_last_i[src]  = with_last && (i == n - 1);
            s_valid_i[src] = 1'b1;
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (!s_ready_o[src] && w < 200);
            tests_run++;
            if (!s_ready_o[src]) begin
                failed++;
                $display("FAIL accept_timeout: src %0d beat %0d ready=0, required 1",
                         src, i);
            end else begin
                e.d    = s_data_i[src];
                e.id   = 1'(src);
                e.dest = dest;
                e.last = s_last_i[src];
                exp_q.push_back(e);
                acc_cyc_q.push_back(cyc);
            end
            @(posedge clk); #1;
        end
        s_valid_i[src] = 1'b0;
        s_last_i[src]  = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk); #1;
        tests_run++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL drain: %0d beats outstanding, required 0",
                     exp_q.size());
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        s_valid_i = 2'b11;
        #1;
        tests_run++;
        if (m_valid_o !== 1'b0 || s_ready_o !== 2'b00 ||
            arb_last_o !== 1'b0 || err_o !== 1'b0 ||
            pkt_cnt_o !== 16'd0 || arb_ready_o !== 1'b1) begin
            failed++;
            $display("FAIL reset: v=%b rdy=%b al=%b err=%b pkt=%0d ar=%b, required 0 00 0 0 0 1",
                     m_valid_o, s_ready_o, arb_last_o, err_o,
                     pkt_cnt_o, arb_ready_o);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        s_valid_i = 2'b00;
        @(negedge clk);
        tests_run++;
        if (s_ready_o !== 2'b00 || m_valid_o !== 1'b0) begin
            failed++;
            $display("FAIL idle_no_grant: rdy=%b v=%b, required 00 0",
                     s_ready_o, m_valid_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        acc_cyc_q.delete();
        pop_cyc_q.delete();
        arb_cnt = 0;
        give_grant(2'b01);
        send_pkt(0, 3, 8'hA1, 2'd0, 1'b1);
        drain();
        tests_run++;
        if (pop_cyc_q.size() != 3 || acc_cyc_q.size() != 3) begin
            failed++;
            $display("FAIL basic_count: pops=%0d accepts=%0d, required 3 3",
                     pop_cyc_q.size(), acc_cyc_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests_run++;
                if (pop_cyc_q[i] != acc_cyc_q[i] + 1 ||
                    acc_cyc_q[i] != acc_cyc_q[0] + i) begin
                    failed++;
                    $display("FAIL basic_timing: beat %0d acc=%0d pop=%0d, required acc=%0d pop=%0d",
                             i, acc_cyc_q[i], pop_cyc_q[i],
                             acc_cyc_q[0] + i, acc_cyc_q[0] + i + 1);
                end
            end
        end
        tests_run++;
        if (arb_cnt != 1 || pkt_cnt_o !== 16'd1) begin
            failed++;
            $display("FAIL basic_pkt: arb_last=%0d pkt=%0d, required 1 1",
                     arb_cnt, pkt_cnt_o);
        end
    endtask

    task automatic test_stall();
        int p0;
        p0 = pops;
        m_ready_i = 1'b0;
        give_grant(2'b01);
        fork
            send_pkt(0, 4, 8'hB0, 2'd0, 1'b1);
            begin
                repeat (6) @(negedge clk);
                tests_run++;
                if (s_ready_o !== 2'b00 || arb_ready_o !== 1'b0 ||
                    m_valid_o !== 1'b1 || m_data_o !== 8'hB0) begin
                    failed++;
                    $display("FAIL stall_full: rdy=%b ar=%b v=%b d=%h, required 00 0 1 b0",
                             s_ready_o, arb_ready_o, m_valid_o, m_data_o);
                end
                @(posedge clk); #1;
                m_ready_i = 1'b1;
            end
        join
        drain();
        tests_run++;
        if (pops - p0 != 4 || pkt_cnt_o !== 16'd2) begin
            failed++;
            $display("FAIL stall_pkt: pops=%0d pkt=%0d, required 4 2",
                     pops - p0, pkt_cnt_o);
        end
    endtask

    task automatic test_dest_err();
        tests_run++;
        if (err_o !== 1'b0) begin
            failed++;
            $display("FAIL err_clean: err=%b, required 0", err_o);
        end
        give_grant(2'b01);
        send_pkt(0, 1, 8'hC5, 2'd2, 1'b1);
        @(negedge clk);
        tests_run++;
        if (err_o !== 1'b1) begin
            failed++;
            $display("FAIL dest_err: err=%b, required 1", err_o);
        end
        drain();
        tests_run++;
        if (pkt_cnt_o !== 16'd3 || err_o !== 1'b1) begin
            failed++;
            $display("FAIL dest_pkt: pkt=%0d err=%b, required 3 1",
                     pkt_cnt_o, err_o);
        end
    endtask

    task automatic test_multi_grant();
        tests_run++;
        if (err_o !== 1'b0 || pkt_cnt_o !== 16'd0) begin
            failed++;
            $display("FAIL rst_clear: err=%b pkt=%0d, required 0 0",
                     err_o, pkt_cnt_o);
        end
        give_grant(2'b11);
        s_valid_i = 2'b11;
        repeat (3) begin
            @(negedge clk);
            tests_run++;
            if (err_o !== 1'b1 || s_ready_o !== 2'b00 ||
                m_valid_o !== 1'b0) begin
                failed++;
                $display("FAIL multi_grant: err=%b rdy=%b v=%b, required 1 00 0",
                         err_o, s_ready_o, m_valid_o);
            end
        end
        @(posedge clk); #1;
        s_valid_i = 2'b00;
        give_grant(2'b10);
        send_pkt(1, 2, 8'hD0, 2'd0, 1'b1);
        drain();
        tests_run++;
        if (pkt_cnt_o !== 16'd1 || err_o !== 1'b1) begin
            failed++;
            $display("FAIL multi_after: pkt=%0d err=%b, required 1 1",
                     pkt_cnt_o, err_o);
        end
    endtask

    task automatic test_lock_hold();
        bit done;
        int n;
        done = 1'b0;
        n = 0;
        give_grant(2'b10);
        fork
            begin
                send_pkt(1, 3, 8'hE0, 2'd0, 1'b1);
                grant_i      = 2'b00;
                s_valid_i[0] = 1'b0;
                s_last_i[0]  = 1'b0;
                done         = 1'b1;
            end
            begin
                @(posedge clk); #1;
                grant_i      = 2'b01;
                s_data_i[0]  = 8'h55;
                s_dest_i[0]  = 2'd0;
                s_last_i[0]  = 1'b1;
                s_valid_i[0] = 1'b1;
                while (!done) begin
                    @(negedge clk);
                    n++;
                    tests_run++;
                    if (s_ready_o[0] !== 1'b0) begin
                        failed++;
                        $display("FAIL lock_hold: rdy0=%b, required 0",
                                 s_ready_o[0]);
                    end
                end
            end
        join
        tests_run++;
        if (n < 2) begin
            failed++;
            $display("FAIL lock_checks: %0d samples, required >= 2", n);
        end
        give_grant(2'b01);
        send_pkt(0, 1, 8'h55, 2'd0, 1'b1);
        drain();
        tests_run++;
        if (pkt_cnt_o !== 16'd3) begin
            failed++;
            $display("FAIL lock_pkt: pkt=%0d, required 3", pkt_cnt_o);
        end
    endtask

    task automatic test_mid_reset();
        m_ready_i = 1'b0;
        give_grant(2'b01);
        send_pkt(0, 2, 8'hF0, 2'd0, 1'b0);
        tests_run++;
        if (m_valid_o !== 1'b1) begin
            failed++;
            $display("FAIL mid_fill: v=%b, required 1", m_valid_o);
        end
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        tests_run++;
        if (m_valid_o !== 1'b0 || pkt_cnt_o !== 16'd0 ||
            s_ready_o !== 2'b00) begin
            failed++;
            $display("FAIL mid_reset: v=%b pkt=%0d rdy=%b, required 0 0 00",
                     m_valid_o, pkt_cnt_o, s_ready_o);
        end
        @(posedge clk); #1;
        rst_n        = 1'b1;
        m_ready_i    = 1'b1;
        s_data_i[0]  = 8'hF2;
        s_valid_i[0] = 1'b1;
        repeat (5) begin
            @(negedge clk);
            tests_run++;
            if (s_ready_o !== 2'b00 || m_valid_o !== 1'b0) begin
                failed++;
                $display("FAIL post_reset: rdy=%b v=%b, required 00 0",
                         s_ready_o, m_valid_o);
            end
        end
        @(posedge clk); #1;
        give_grant(2'b01);
        send_pkt(0, 3, 8'hF2, 2'd0, 1'b1);
        drain();
        tests_run++;
        if (pkt_cnt_o !== 16'd1) begin
            failed++;
            $display("FAIL mid_pkt: pkt=%0d, required 1", pkt_cnt_o);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        tests_run = 0;
        failed    = 0;
        cyc       = 0;
        pops      = 0;
        arb_cnt   = 0;
        rst_n     = 1'b0;
        s_data_i  = '0;
        s_dest_i  = '0;
        s_last_i  = '0;
        s_valid_i = '0;
        grant_i   = '0;
        m_ready_i = 1'b1;
        test_reset();
        test_basic();
        test_stall();
        test_dest_err();
        do_reset();
        test_multi_grant();
        test_lock_hold();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule

// File: doc/crossbar_out_port.md
CROSSBAR_OUT_PORT -- requirements
Module: crossbar_out_port

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- S_DATA_COUNT, 2, number of slave (source) ports.
- M_DATA_COUNT, 3, number of master (destination) ports.
- T_DATA_WIDTH, 8, data beat width in bits.
- PORT_NUMBER, 0, index of the master port this instance drives.
- Derived: T_ID___WIDTH = $clog2(S_DATA_COUNT); T_DEST_WIDTH = $clog2(M_DATA_COUNT).
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, clock; all state updates on rising edge.
- rst_n, in, 1, reset; asynchronous, active-low.
- s_data_i, in, [S_DATA_COUNT] x T_DATA_WIDTH, per-source beat data.
- s_dest_i, in, [S_DATA_COUNT] x T_DEST_WIDTH, per-source destination.
- s_last_i, in, S_DATA_COUNT, per-source last-beat flag.
- s_valid_i, in, S_DATA_COUNT, per-source valid.
- s_ready_o, out, S_DATA_COUNT, per-source ready.
- grant_i, in, S_DATA_COUNT, grant vector from the round-robin arbiter of this port.
- arb_ready_o, out, 1, output-side-can-accept indication to the arbiter.
- arb_last_o, out, 1, pulse: last beat of current packet accepted from source.
- m_data_o, out, T_DATA_WIDTH, output beat data.
- m_id_o, out, T_ID___WIDTH, index of the source the beat came from.
- m_dest_o, out, T_DEST_WIDTH, destination of the beat.
- m_last_o, out, 1, output last flag.
- m_valid_o, out, 1, output valid.
- m_ready_i, in, 1, output ready from downstream sink.
- err_o, out, 1, sticky protocol error.
- pkt_cnt_o, out, 16, packets delivered on the output.

Function
REQ-003 The FSM SHALL have two states: IDLE and LOCKED.
REQ-004 In IDLE, the block SHALL accept grant_i only when exactly one bit is set; it SHALL latch that index into sel and enter LOCKED next cycle.
REQ-005 In IDLE, a grant_i with more than one bit set SHALL be ignored, SHALL leave the state IDLE and SHALL set err_o.
REQ-006 In LOCKED, grant_i SHALL be ignored.
REQ-007 The block SHALL contain a 2-entry output FIFO holding {data, id, dest, last}, with occupancy count 0..2.
REQ-008 s_ready_o[sel] SHALL be 1 iff state is LOCKED and count < 2; all other s_ready_o bits SHALL be 0; s_ready_o SHALL be driven from registered state only.
REQ-009 A beat SHALL be accepted when s_valid_i[sel] and s_ready_o[sel] are both 1; it SHALL be pushed with id=sel.
REQ-010 An accepted beat with s_dest_i[sel] != PORT_NUMBER SHALL still be pushed and SHALL set err_o.
REQ-011 An accepted beat with s_last_i[sel]=1 SHALL pulse arb_last_o in that cycle and SHALL return the FSM to IDLE on the next cycle.
REQ-012 m_valid_o SHALL equal (count != 0); m_* SHALL present the FIFO head; a pop SHALL occur when m_valid_o and m_ready_i are both 1.
REQ-013 Latency SHALL be 1 cycle: a beat accepted in cycle N with count=0 SHALL appear on m_* in cycle N+1.
REQ-014 Simultaneous push and pop SHALL leave count unchanged and preserve order; with continuous m_ready_i the throughput SHALL be 1 beat/cycle.
REQ-015 m_* outputs SHALL hold stable while m_valid_o=1 and m_ready_i=0.
REQ-016 arb_ready_o SHALL equal (count != 2).
REQ-017 pkt_cnt_o SHALL increment by 1 on each pop with m_last_o=1; it SHALL wrap from 0xFFFF to 0.
REQ-018 err_o SHALL remain 1 once set, until reset.

Reset
REQ-019 While rst_n=0 (asynchronous), the block SHALL force: state IDLE, sel 0, count 0, m_valid_o 0, s_ready_o 0, arb_last_o 0, err_o 0, pkt_cnt_o 0.
REQ-020 Reset asserted mid-packet SHALL discard FIFO contents and the lock; after release the block SHALL wait for a new grant.

Verification
REQ-021 Grant 2'b01, source 0 sends 3 beats (0xA1,0xA2,0xA3 with last), m_ready_i=1 -> m_data_o 0xA1..0xA3 on consecutive cycles, m_id_o=0, arb_last_o pulse once, pkt_cnt_o=1.
REQ-022 m_ready_i=0 during a 4-beat packet -> count reaches 2, s_ready_o[sel]=0, arb_ready_o=0, m_* stable; on release all 4 beats delivered in order, no loss or duplicate.
REQ-023 grant_i=2'b11 in IDLE -> err_o=1, no s_ready_o asserted; a subsequent grant 2'b10 is then served normally with m_id_o=1.
REQ-024 Source 1 locked, source 0 valid and grant_i toggles to 2'b01 mid-packet -> s_ready_o[0] stays 0 until source 1 last beat is accepted.
REQ-025 rst_n pulsed low after 2 of 5 beats -> m_valid_o=0 immediately, pkt_cnt_o=0; after release no beat is output until a new grant is given.
